// File: rtl/signal_analyser_pkg.sv
// Shared widths and types for the signal analyser change detector.
// Build option: SIGNAL_ANALYSER_CHANGE_CNT_EN adds the changeCount output.
package signal_analyser_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TIME_W = 32;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_TIME_W-1:0] time_t;

endpackage

// File: rtl/sa_timestamp_counter.sv
// Free-running timestamp counter, wraps modulo 2^TIME_W.
// Ports: clk, rst (async, active-low), count (current timestamp).
module sa_timestamp_counter #(
  parameter int TIME_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TIME_W-1:0] count
);

  logic [TIME_W-1:0] count_q;
  logic [TIME_W-1:0] count_d;

  always_comb begin
    count_d = count_q + TIME_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/signal_analyser.sv
// Change detector / timestamper for a sampled parallel signal.
// Ports: clk, rst (async active-low), dataIn -> dataOut, dataTime,
// newData (1-cycle pulse on each captured change), and changeCount
// when SIGNAL_ANALYSER_CHANGE_CNT_EN is defined (saturating count).
module signal_analyser
  import signal_analyser_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIME_W = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  output logic [TIME_W-1:0] dataTime,
  output logic [DATA_W-1:0] dataOut,
  output logic              newData
`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
  ,
  output logic [TIME_W-1:0] changeCount
`endif
);

  logic [TIME_W-1:0] count;

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] prev_d;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic [TIME_W-1:0] data_time_q;
  logic [TIME_W-1:0] data_time_d;
  logic              new_data_q;
  logic              new_data_d;
  logic              changed;

  sa_timestamp_counter #(
    .TIME_W(TIME_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .count(count)
  );

  assign changed = (dataIn != prev_q);

  // The stamp is the counter's pre-increment value at this edge.
  always_comb begin
    prev_d      = prev_q;
    data_out_d  = data_out_q;
    data_time_d = data_time_q;
    new_data_d  = 1'b0;
    if (changed) begin
      prev_d      = dataIn;
      data_out_d  = dataIn;
      data_time_d = count;
      new_data_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      data_out_q  <= '0;
      data_time_q <= '0;
      new_data_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      data_out_q  <= data_out_d;
      data_time_q <= data_time_d;
      new_data_q  <= new_data_d;
    end
  end

  assign dataOut  = data_out_q;
  assign dataTime = data_time_q;
  assign newData  = new_data_q;

`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
  logic [TIME_W-1:0] chg_cnt_q;
  logic [TIME_W-1:0] chg_cnt_d;

  // Sticks at all-ones instead of wrapping.
  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if (changed && (chg_cnt_q != '1)) begin
      chg_cnt_d = chg_cnt_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign changeCount = chg_cnt_q;
`endif

endmodule

// File: tb/tb_signal_analyser.sv
// Self-checking bench for signal_analyser: 32-bit and 4-bit timebase
// instances driven in parallel against a behavioural change model.
module tb_signal_analyser;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;

  logic [31:0] dtime32;
  logic [7:0]  dout32;
  logic        nd32;
  logic [3:0]  dtime4;
  logic [7:0]  dout4;
  logic        nd4;

  int vectors;
  int miscompares;

  // Reference model state
  logic [7:0]  m_prev;
  logic [7:0]  m_out;
  logic [31:0] m_time;
  logic        m_nd;
  logic [31:0] m_n;
  int          m_cc;

`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
  logic [31:0] cc32;
  logic [3:0]  cc4;
`endif

  signal_analyser u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (data_in),
    .dataTime(dtime32),
    .dataOut (dout32),
    .newData (nd32)
`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
    ,
    .changeCount(cc32)
`endif
  );

  signal_analyser #(
    .DATA_W(8),
    .TIME_W(4)
  ) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (data_in),
    .dataTime(dtime4),
    .dataOut (dout4),
    .newData (nd4)
`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
    ,
    .changeCount(cc4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [53:0] act_vec;
  assign act_vec = {dout32, dtime32, nd32, dout4, dtime4, nd4};

  function automatic logic [53:0] exp_vec();
    return {m_out, m_time, m_nd, m_out, m_time[3:0], m_nd};
  endfunction

  task automatic model_reset();
    m_prev = '0;
    m_out  = '0;
    m_time = '0;
    m_nd   = 1'b0;
    m_n    = '0;
    m_cc   = 0;
  endtask

  // Apply one value at the next edge, update the model, settle.
  task automatic drive(input logic [7:0] v);
    data_in = v;
    @(posedge clk);
    if (v != m_prev) begin
      m_out  = v;
      m_time = m_n;
      m_nd   = 1'b1;
      m_prev = v;
      m_cc++;
    end else begin
      m_nd = 1'b0;
    end
    m_n = m_n + 1;
    #1;
  endtask

  // Reset pulse released mid-cycle, away from clock edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    data_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 8'h00;
    #2;
    rst = 1'b0;
    #2;
    model_reset();
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", act_vec, exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_first_change();
    drive(8'd69);
    vectors++;
    if (act_vec !== exp_vec() || dtime32 !== 32'd0 || nd32 !== 1'b1) begin
      miscompares++;
      $display("FAIL first_change: got %h want %h", act_vec, exp_vec());
    end
    drive(8'd69);
    vectors++;
    if (act_vec !== exp_vec() || nd32 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_late_change();
    drive(8'd69);
    drive(8'd100);
    vectors++;
    if (act_vec !== exp_vec() || dtime32 !== 32'd3 || dout32 !== 8'd100) begin
      miscompares++;
      $display("FAIL late_change: got %h want %h", act_vec, exp_vec());
    end
    drive(8'd100);
    vectors++;
    if (act_vec !== exp_vec() || nd32 !== 1'b0) begin
      miscompares++;
      $display("FAIL late_hold: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t0;
    t0 = m_n;
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? 8'h55 : 8'hAA);
      vectors++;
      if (act_vec !== exp_vec() || nd32 !== 1'b1 || dtime32 !== t0 + i) begin
        miscompares++;
        $display("FAIL toggle[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(8'h12);
    drive(8'h34);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", act_vec, exp_vec());
    end
    @(posedge clk);
    #1;
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", act_vec, exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    drive(8'h00);
    vectors++;
    if (act_vec !== exp_vec() || nd32 !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_first: got %h want %h", act_vec, exp_vec());
    end
    drive(8'h33);
    vectors++;
    if (act_vec !== exp_vec() || dtime32 !== 32'd1) begin
      miscompares++;
      $display("FAIL restamp: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 8'hF0 : 8'h0F);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
      vectors++;
      if (cc32 !== 32'(m_cc) || cc4 !== 4'((m_cc > 15) ? 15 : m_cc)) begin
        miscompares++;
        $display("FAIL wrap_cnt[%0d]: got %0d/%0d want %0d", i, cc32, cc4, m_cc);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) v = m_prev;
      else v = 8'($urandom_range(0, 255));
      drive(v);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
`ifdef SIGNAL_ANALYSER_CHANGE_CNT_EN
      vectors++;
      if (cc32 !== 32'(m_cc) || cc4 !== 4'((m_cc > 15) ? 15 : m_cc)) begin
        miscompares++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d", i, cc32, cc4, m_cc);
      end
`endif
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_first_change();
    test_late_change();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
